// File: rtl/swipt_frame_scheduler_if.sv
// Link-side bundle between the frame scheduler (master) and the bit-serial SWIPT
// transceiver (slave).
interface swipt_frame_scheduler_if;
    logic        link_busy;
    logic        link_done;
    logic        link_ok;
    logic [7:0]  link_rx;
    logic        link_start;
    logic [1:0]  link_mode;
    logic [1:0]  link_type;
    logic [15:0] link_payload;

    modport master (
        input  link_busy, link_done, link_ok, link_rx,
        output link_start, link_mode, link_type, link_payload
    );

    modport slave (
        output link_busy, link_done, link_ok, link_rx,
        input  link_start, link_mode, link_type, link_payload
    );
endinterface

// File: rtl/swipt_frame_scheduler.sv
// SWIPT link frame scheduler: round-robin channel arbitration, watchdog-supervised
// transactions with bounded retries, periodic refresh and answer capture.
module swipt_frame_scheduler #(
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [23:0] WDOG_CYCLES    = 24'd12_000_000,
    parameter logic [15:0] GAP_CYCLES     = 16'd1000,
    parameter logic [27:0] REFRESH_CYCLES = 28'd100_000_000
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    swipt_alive,
    input  logic [1:0]              prog,
    input  logic [127:0]            ch_data,
    input  logic [7:0]              ch_en,
    swipt_frame_scheduler_if.master link,
    output logic [7:0]              rx_power,
    output logic [7:0]              rx_eff,
    output logic [7:0]              tx_count,
    output logic [7:0]              err_count,
    output logic                    busy
);

    typedef enum logic [2:0] {StIdle, StArb, StStart, StWait, StGap} state_e;

    state_e      state_q;
    logic [7:0]  pending_q;
    logic [15:0] last_sent_q [8];
    logic [2:0]  rr_ptr_q, grant_q;
    logic [7:0]  retry_q;
    logic [27:0] refresh_q;
    logic [23:0] timer_q;
    logic        link_start_q;
    logic [1:0]  link_mode_q, link_type_q;
    logic [15:0] link_payload_q;
    logic [7:0]  rx_power_q, rx_eff_q, tx_count_q, err_count_q;

    logic        active, refresh_hit;
    logic        success, failure, drop;
    logic [15:0] ch_word [8];
    logic [7:0]  set_vec, clr_vec, pending_d;
    logic        arb_found;
    logic [2:0]  arb_idx, cand;
    logic [1:0]  arb_mode, arb_ftype;

    always_comb begin
        active      = swipt_alive && (prog == 2'b11);
        refresh_hit = (refresh_q == REFRESH_CYCLES - 28'd1);
        for (int i = 0; i < 8; i++) begin
            ch_word[i] = ch_data[16*i +: 16];
        end

        success = (state_q == StWait) && link.link_done && link.link_ok;
        failure = (state_q == StWait) &&
                  (link.link_done ? !link.link_ok : (timer_q == WDOG_CYCLES - 24'd1));
        drop    = failure && (retry_q >= 8'(MAX_RETRY));

        set_vec = refresh_hit ? ch_en : 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (ch_word[i] != last_sent_q[i]) set_vec[i] = 1'b1;
        end
        clr_vec = 8'h00;
        if (success) begin
            // last_sent takes the snapshot this cycle, so compare against the snapshot.
            set_vec[grant_q] = refresh_hit || (ch_word[grant_q] != link_payload_q);
            clr_vec[grant_q] = 1'b1;
        end else if (drop) begin
            set_vec[grant_q] = 1'b0;
            clr_vec[grant_q] = 1'b1;
        end
        pending_d = ((pending_q & ~clr_vec) | set_vec) & ch_en;

        // First pending channel strictly after rr_ptr, wrapping; rr_ptr itself is last.
        arb_found = 1'b0;
        arb_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 1; k <= 8; k++) begin
            cand = rr_ptr_q + 3'(k);
            if (!arb_found && pending_q[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        if (!arb_idx[2]) begin
            arb_mode  = 2'b00;
            arb_ftype = arb_idx[1:0];
        end else begin
            arb_mode  = arb_idx[1] ? 2'b10 : 2'b01;
            arb_ftype = {1'b0, arb_idx[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= StIdle;
            pending_q      <= 8'h00;
            for (int i = 0; i < 8; i++) last_sent_q[i] <= 16'h0000;
            rr_ptr_q       <= 3'd7;
            grant_q        <= 3'd0;
            retry_q        <= 8'd0;
            refresh_q      <= 28'd0;
            timer_q        <= 24'd0;
            link_start_q   <= 1'b0;
            link_mode_q    <= 2'b00;
            link_type_q    <= 2'b00;
            link_payload_q <= 16'h0000;
            rx_power_q     <= 8'h00;
            rx_eff_q       <= 8'h00;
            tx_count_q     <= 8'h00;
            err_count_q    <= 8'h00;
        end else if (!active) begin
            state_q      <= StIdle;
            link_start_q <= 1'b0;
            pending_q    <= 8'h00;
            retry_q      <= 8'd0;
            refresh_q    <= 28'd0;
        end else begin
            link_start_q <= 1'b0;
            pending_q    <= pending_d;
            refresh_q    <= refresh_hit ? 28'd0 : refresh_q + 28'd1;
            unique case (state_q)
                StIdle: begin
                    if (pending_q != 8'h00) state_q <= StArb;
                end
                StArb: begin
                    if (arb_found) begin
                        grant_q        <= arb_idx;
                        rr_ptr_q       <= arb_idx;
                        link_payload_q <= ch_word[arb_idx];
                        link_mode_q    <= arb_mode;
                        link_type_q    <= arb_ftype;
                        state_q        <= StStart;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StStart: begin
                    if (!link.link_busy) begin
                        link_start_q <= 1'b1;
                        timer_q      <= 24'd0;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    timer_q <= timer_q + 24'd1;
                    if (success) begin
                        last_sent_q[grant_q] <= link_payload_q;
                        if (tx_count_q != 8'hFF) tx_count_q <= tx_count_q + 8'd1;
                        retry_q <= 8'd0;
                        if (link_mode_q == 2'b00 && link_type_q == 2'b00) rx_power_q <= link.link_rx;
                        if (link_mode_q == 2'b00 && link_type_q == 2'b01) rx_eff_q <= link.link_rx;
                        timer_q <= 24'd0;
                        state_q <= StGap;
                    end else if (failure) begin
                        if (drop) begin
                            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                            retry_q <= 8'd0;
                        end else begin
                            retry_q <= retry_q + 8'd1;
                        end
                        timer_q <= 24'd0;
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    timer_q <= timer_q + 24'd1;
                    if (timer_q[15:0] == GAP_CYCLES - 16'd1) begin
                        state_q <= (retry_q != 8'd0) ? StStart : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign link.link_start   = link_start_q;
    assign link.link_mode    = link_mode_q;
    assign link.link_type    = link_type_q;
    assign link.link_payload = link_payload_q;
    assign rx_power          = rx_power_q;
    assign rx_eff            = rx_eff_q;
    assign tx_count          = tx_count_q;
    assign err_count         = err_count_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: doc/swipt_frame_scheduler.md
Name: swipt_frame_scheduler

Overview:
- Sequences the SWIPT serial data link. Decides which of eight 16-bit telemetry channels is sent next and drives the link's mode/type/payload.
- Starts each link transaction, then supervises it with a watchdog, bounded retries and round-robin fairness.
- Captures the 8-bit answers for power and efficiency. Sits between the telemetry register bank and the bit-serial link transceiver.

Parameters:
- MAX_RETRY, 3, retransmissions after the first attempt before a frame is dropped.
- WDOG_CYCLES, 24'd12_000_000, cycles from link_start to link_done before a timeout is declared.
- GAP_CYCLES, 16'd1000, idle cycles enforced between consecutive transactions.
- REFRESH_CYCLES, 28'd100_000_000, period of the forced re-send of every enabled channel.

Ports:
- clk  in  1  system clock
- nrst  in  1  sync reset, active-low
- swipt_alive  in  1  link powered
- program  in  2  active only when 2'b11
- ch_data  in  128  channel i at bits [16i+15:16i]
- ch_en  in  8  per-channel enable mask
- link_busy  in  1  transceiver busy
- link_done  in  1  1-cycle pulse, transaction finished
- link_ok  in  1  valid with link_done; answer checksum good
- link_rx  in  8  valid with link_done; answer byte
- link_start  out  1  1-cycle start pulse
- link_mode  out  2  frame mode field
- link_type  out  2  frame type field
- link_payload  out  16  frame payload
- rx_power  out  8  last power answer
- rx_eff  out  8  last efficiency answer
- tx_count  out  8  acknowledged frames, saturating
- err_count  out  8  dropped frames, saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset is nrst, synchronous, active-low; clock is clk.
- On reset: all outputs 0, FSM IDLE, pending = 0, last_sent = 0, rr_ptr = 7, retry = 0, refresh and watchdog counters 0.
- active = swipt_alive && program == 2'b11.
- When !active: FSM forced to IDLE, link_start = 0, pending cleared, retry = 0, refresh counter cleared. rx_power, rx_eff, tx_count, err_count and last_sent hold.
- Channel code, ch0-3: mode 00, type = i[1:0]. ch4-5: mode 01, type = {1'b0, i[0]}. ch6-7: mode 10, type = {1'b0, i[0]}.
- Pending set rules:
  - pending[i] sets when ch_en[i] && ch_data[i] != last_sent[i], evaluated every active cycle.
  - All enabled bits set when the refresh counter reaches REFRESH_CYCLES-1; the counter then wraps to 0.
  - A disabled channel's pending bit is cleared immediately.
- FSM states:
  - IDLE: if active and pending != 0, go to ARB.
  - ARB, 1 cycle: grant the first pending index after rr_ptr, searching upward modulo 8. Set rr_ptr = grant. Snapshot ch_data[grant] into link_payload and drive link_mode/link_type. Go to START.
  - START: wait while link_busy = 1. When link_busy = 0, pulse link_start for exactly 1 cycle, clear the watchdog, go to WAIT.
  - WAIT: watchdog increments each cycle. Exit on link_done, or on timeout when the watchdog reaches WDOG_CYCLES-1. If link_done and timeout coincide, link_done wins.
  - Success (link_done && link_ok):
    - last_sent[grant] = snapshot; pending[grant] cleared.
    - tx_count++; retry = 0.
    - Code 00/00 loads rx_power = link_rx. Code 00/01 loads rx_eff = link_rx. Other codes discard link_rx.
    - Go to GAP.
  - Failure (link_done && !link_ok, or timeout):
    - If retry < MAX_RETRY: retry++, go to GAP, then return to START with the same grant and same snapshot (no re-arbitration).
    - Otherwise: pending[grant] cleared, last_sent not updated (so a still-differing value re-pends next cycle), err_count++, retry = 0, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE (or to START when a retry is outstanding).
- link_mode, link_type and link_payload are stable from ARB until the next ARB. ch_data changes after the snapshot do not affect the frame in flight.
- Pending-set has priority over the success-clear in the same cycle only if ch_data[grant] != snapshot.
- tx_count and err_count saturate at 8'hFF.
- link_done outside WAIT is ignored.
- busy = (state != IDLE).

Test Plan:
- ch_en = 8'h01, ch_data[0] = 16'h1234, link answers done/ok with link_rx = 8'h5A after 100 cycles → one link_start, mode = 00, type = 00, payload = 16'h1234, rx_power = 8'h5A, tx_count = 1, no further start after GAP.
- ch_en = 8'hFF, all channels differ from last_sent, always ok → grants 0,1,…,7 in order, each separated by ≥ GAP_CYCLES, channel 5 carries mode 01 type 01.
- Channel 1 answered with link_ok = 0 four times → 4 starts (1 + MAX_RETRY), all with an identical payload, err_count = 1, rx_eff unchanged.
- No link_done → timeout after WDOG_CYCLES, retries as above; link_done arriving on the timeout cycle with ok = 1 → counted as success.
- program changed to 2'b01 while in WAIT → next cycle state IDLE, busy = 0, pending = 0, tx_count held; restoring 2'b11 re-pends differing channels.
- link_busy held high for 50 cycles in START → link_start asserts on the first cycle after link_busy falls; changing ch_data[grant] mid-WAIT → success is followed by a second send with the new value.
